// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding
// and parity mode constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled
// and pulses bit_done on the final cycle of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_done
);

  localparam int W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  // counter held at zero while idle so each frame starts aligned
  always_ff @(posedge clk) begin
    if (rst || !enable)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

  assign bit_done = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: valid/ready input,
// start/data/parity/stop framing on a registered tx line.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IW = $clog2(DATA_BITS) + 1;
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_pm
    $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  state_t               state, state_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic [IW-1:0]        idx, idx_d;
  logic                 par, par_d;
  logic                 tx_d;
  logic                 bit_done;
  logic                 accept;
  logic                 par_in;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .enable  (state != IDLE),
    .bit_done(bit_done)
  );

  assign busy     = (state != IDLE);
  assign tx_ready = (state == IDLE) ||
                    (state == STOP && idx == LAST_STOP && bit_done);
  assign accept   = tx_valid && tx_ready;
  assign par_in   = (^tx_data) ^ (PARITY_MODE == PARITY_ODD);

  // next-state, shift register and next tx level
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    idx_d   = idx;
    par_d   = par;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shreg_d = tx_data;
          par_d   = par_in;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shreg_d = shreg >> 1;
          if (idx == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (idx == LAST_STOP) begin
            idx_d = '0;
            if (accept) begin
              state_d = START;
              shreg_d = tx_data;
              par_d   = par_in;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    unique case (1'b1)
      (state_d == START):  tx_d = 1'b0;
      (state_d == DATA):   tx_d = shreg_d[0];
      (state_d == PARITY): tx_d = par_d;
      default:             tx_d = 1'b1;
    endcase
  end

  // state register; reset aborts any frame and drops handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      idx   <= idx_d;
      par   <= par_d;
      tx    <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868: clk cycles per serial bit; legal range is 2 or more.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range is 5 to 9.
REQ-003 Parameter PARITY_MODE, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: number of stop bits; legal values are 1 or 2.
REQ-005 clk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 tx_valid  input  1  producer offers a frame.
REQ-008 tx_data  input  DATA_BITS  payload; sampled only at handshake.
REQ-009 tx_ready  output  1  block can accept a frame this cycle.
REQ-010 tx  output  1  serial line; registered; idles high.
REQ-011 busy  output  1  high whenever a frame is in progress (state != IDLE).

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- PARITY is skipped when PARITY_MODE = 0.
REQ-013 Handshake: a frame SHALL be accepted on any rising edge where tx_valid and tx_ready are both 1.
- At acceptance, tx_data is captured into an internal shift register.
- Later changes on tx_data SHALL have no effect on the frame in progress.
REQ-014 tx_ready SHALL be 1 in IDLE, and 1 during the final clk cycle of the last stop bit; 0 otherwise.
REQ-015 Latency: tx SHALL drive the start bit (0) in the first cycle after the acceptance edge.
REQ-016 Each bit (start, data, parity, stop) SHALL be held on tx for exactly CLKS_PER_BIT cycles.
- Timing is counted by a baud counter that runs 0..CLKS_PER_BIT-1 and wraps.
REQ-017 Data bits SHALL be sent LSB first, DATA_BITS of them.
- Bit index counts 0..DATA_BITS-1; the DATA to PARITY/STOP transition happens on the wrap after index DATA_BITS-1.
REQ-018 Parity bit values:
- Even mode: XOR of the captured data.
- Odd mode: inverse of that XOR.
REQ-019 Stop phase SHALL drive tx = 1 for STOP_BITS x CLKS_PER_BIT cycles.
REQ-020 Frame duration SHALL be (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) x CLKS_PER_BIT cycles.
REQ-021 Back-to-back: if a frame is accepted in the last stop cycle, START SHALL follow immediately with no idle bit.
REQ-022 If tx_valid is low at the end of the stop phase, the FSM SHALL enter IDLE with tx = 1 and busy = 0.
REQ-023 tx_valid asserted while tx_ready = 0 SHALL be ignored; the producer holds it until the handshake completes.
REQ-024 Counter widths:
- Baud counter: $clog2(CLKS_PER_BIT).
- Bit index: $clog2(DATA_BITS) + 1.
- Both SHALL wrap without overflow.
REQ-025 Illegal parameter values SHALL trigger an elaboration-time error.

Reset
REQ-026 While rst = 1 at a rising edge, the block SHALL enter the following state on that edge:
- state = IDLE; tx = 1; tx_ready = 1; busy = 0.
- Baud counter, bit index and shift register = 0.
REQ-027 Reset mid-frame SHALL abort the frame; tx returns high on that edge and no partial bits resume.
REQ-028 A handshake in the same cycle as rst = 1 SHALL be discarded.

Structure
REQ-029 A shared package uart_pkg SHALL hold:
- the state encoding (IDLE, START, DATA, PARITY, STOP);
- the PARITY_NONE/ODD/EVEN constants.
REQ-030 The baud counter SHALL be a sub-module, uart_baud_gen.
- Parameter: CLKS_PER_BIT.
- Ports: clk, rst, enable, bit_done pulse.
- uart_tx_cfg holds FSM, shift register and parity logic.

Verification
REQ-031 Plain frame (CLKS_PER_BIT=4, 8N1): send 0xA5 -> tx reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total; busy drops at cycle 40.
REQ-032 Parity frames (CLKS_PER_BIT=4, PARITY_MODE=2, 0x07) -> parity bit 1, frame 44 cycles; PARITY_MODE=1 with 0x07 -> parity bit 0.
REQ-033 Back-to-back (8N2, CLKS_PER_BIT=4): 0x55 then 0xAA with tx_valid held -> second start bit begins at cycle 44 after the first, with no idle high gap.
REQ-034 Short data (DATA_BITS=5, 8N1 otherwise): send 0x1F5 on a 5-bit bus (value 0x15) -> bits 1,0,1,0,1, frame 28 cycles at CLKS_PER_BIT=4.
REQ-035 Reset mid-frame: assert rst during data bit 3 -> next cycle tx = 1, tx_ready = 1, busy = 0; a new frame of 0x3C then transmits correctly.
REQ-036 Handshake hold: change tx_data every cycle after acceptance of 0x81 -> serial output still 0x81; tx_valid while busy is not accepted until the last stop cycle.
